butterfly_r2_pipe: RTL and testbench

- Parametrised, fully pipelined radix-2 complex butterfly for the FFT datapath.
- Successor to the fixed 24-bit/Q2.13 butterfly. Adds:
  - generic data and twiddle widths;
  - DIT/DIF selection;
  - per-sample inverse (conjugate twiddle) and divide-by-2 scaling;
  - round-half-up and output saturation with a sticky overflow flag;
  - valid/ready backpressure.
- Sits between the FFT address/memory controller and the stage RAM write-back.

---
 rtl/fft_pkg.sv | 38 +++
 rtl/cmult_round.sv | 64 ++++++
 rtl/butterfly_r2_pipe.sv | 172 +++++++++++++++++
 tb/tb_butterfly_r2_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath widths, rounding constant and saturation helpers
package fft_pkg;

    localparam int FFT_DW = 24;
    localparam int FFT_TW = 16;
    localparam int FFT_TF = 13;

    localparam longint FFT_RND     = longint'(1) <<< (FFT_TF - 1);
    localparam longint FFT_SAT_MAX = (longint'(1) <<< (FFT_DW - 1)) - 1;
    localparam longint FFT_SAT_MIN = -(longint'(1) <<< (FFT_DW - 1));

    function automatic longint round_const(input int tf);
        return longint'(1) <<< (tf - 1);
    endfunction

    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

    // Callers sign-extend into 64 bits and truncate the result back to dw bits.
    function automatic longint sat(input longint x, input int dw);
        if (x > sat_max(dw)) begin
            return sat_max(dw);
        end else if (x < sat_min(dw)) begin
            return sat_min(dw);
        end
        return x;
    endfunction

    function automatic logic sat_hit(input longint x, input int dw);
        return (x > sat_max(dw)) || (x < sat_min(dw));
    endfunction

endpackage

// File: rtl/cmult_round.sv
// rtl/cmult_round.sv - two-stage complex multiply with optional conjugate twiddle and round-half-up
module cmult_round
    import fft_pkg::*;
#(
    parameter int XW = FFT_DW + 1,
    parameter int TW = FFT_TW,
    parameter int TF = FFT_TF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic signed [XW-1:0]     x_re,
    input  logic signed [XW-1:0]     x_im,
    input  logic signed [TW-1:0]     w_re,
    input  logic signed [TW-1:0]     w_im,
    input  logic                     conj,
    output logic signed [XW+TW+1:0]  y_re,
    output logic signed [XW+TW+1:0]  y_im
);

    localparam int PW = XW + TW + 1;
    localparam int CW = PW + 1;
    localparam logic signed [CW-1:0] RND = CW'(round_const(TF));

    logic signed [XW-1:0] xr_q, xi_q;
    logic signed [TW:0]   wr_q, wi_q;
    logic signed [TW:0]   w_re_x, w_im_x, wi_d;

    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [CW-1:0] re_sum, im_sum;

    // One extra bit so conjugating -2^(TW-1) stays representable.
    assign w_re_x = {w_re[TW-1], w_re};
    assign w_im_x = {w_im[TW-1], w_im};
    assign wi_d   = conj ? -w_im_x : w_im_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            xr_q   <= '0;
            xi_q   <= '0;
            wr_q   <= '0;
            wi_q   <= '0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
        end else if (ce) begin
            xr_q   <= x_re;
            xi_q   <= x_im;
            wr_q   <= w_re_x;
            wi_q   <= wi_d;
            p_rr_q <= PW'(xr_q) * PW'(wr_q);
            p_ii_q <= PW'(xi_q) * PW'(wi_q);
            p_ri_q <= PW'(xr_q) * PW'(wi_q);
            p_ir_q <= PW'(xi_q) * PW'(wr_q);
        end
    end

    assign re_sum = CW'(p_rr_q) - CW'(p_ii_q) + RND;
    assign im_sum = CW'(p_ri_q) + CW'(p_ir_q) + RND;
    assign y_re   = re_sum >>> TF;
    assign y_im   = im_sum >>> TF;

endmodule

// File: rtl/butterfly_r2_pipe.sv
// rtl/butterfly_r2_pipe.sv - three-stage radix-2 DIT/DIF butterfly with scaling, saturation and backpressure
module butterfly_r2_pipe
    import fft_pkg::*;
#(
    parameter int DW  = FFT_DW,
    parameter int TW  = FFT_TW,
    parameter int TF  = FFT_TF,
    parameter int DIF = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    input  logic                 inverse,
    input  logic                 scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] outa_re,
    output logic signed [DW-1:0] outa_im,
    output logic signed [DW-1:0] outb_re,
    output logic signed [DW-1:0] outb_im,
    output logic                 ovf_flag,
    input  logic                 ovf_clr
);

    localparam int XW = DW + 1;
    localparam int CW = XW + TW + 2;
    localparam int SW = CW + 1;

    logic ce;
    logic v1_q, v2_q, out_valid_q, ovf_q, ovf_d;
    logic scale1_q, scale2_q;

    logic signed [DW-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
    logic signed [XW-1:0] x_re_d, x_im_d;
    logic signed [XW-1:0] p_re_d, p_im_d, p_re_q, p_im_q;
    logic signed [CW-1:0] y_re, y_im;

    logic signed [SW-1:0] sa_re, sa_im, sb_re, sb_im;
    logic signed [SW-1:0] ha_re, ha_im, hb_re, hb_im;
    logic signed [DW-1:0] outa_re_d, outa_im_d, outb_re_d, outb_im_d;
    logic signed [DW-1:0] outa_re_q, outa_im_q, outb_re_q, outb_im_q;
    logic                 clamp_d;

    assign ce       = !out_valid_q || out_ready;
    assign in_ready = ce;

    // DIT multiplies b by the twiddle; DIF multiplies the widened difference a-b.
    always_comb begin
        if (DIF != 0) begin
            x_re_d = XW'(a_re) - XW'(b_re);
            x_im_d = XW'(a_im) - XW'(b_im);
        end else begin
            x_re_d = XW'(b_re);
            x_im_d = XW'(b_im);
        end
    end

    cmult_round #(
        .XW(XW),
        .TW(TW),
        .TF(TF)
    ) u_cmult (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .x_re (x_re_d),
        .x_im (x_im_d),
        .w_re (w_re),
        .w_im (w_im),
        .conj (inverse),
        .y_re (y_re),
        .y_im (y_im)
    );

    assign p_re_d = (DIF != 0) ? XW'(a_re_q) + XW'(b_re_q) : XW'(a_re_q);
    assign p_im_d = (DIF != 0) ? XW'(a_im_q) + XW'(b_im_q) : XW'(a_im_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            scale1_q <= 1'b0;
            scale2_q <= 1'b0;
            a_re_q   <= '0;
            a_im_q   <= '0;
            b_re_q   <= '0;
            b_im_q   <= '0;
            p_re_q   <= '0;
            p_im_q   <= '0;
        end else if (ce) begin
            v1_q     <= in_valid;
            v2_q     <= v1_q;
            scale1_q <= scale;
            scale2_q <= scale1_q;
            a_re_q   <= a_re;
            a_im_q   <= a_im;
            b_re_q   <= b_re;
            b_im_q   <= b_im;
            p_re_q   <= p_re_d;
            p_im_q   <= p_im_d;
        end
    end

    function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] v, input logic en);
        return en ? (v + SW'(1)) >>> 1 : v;
    endfunction

    always_comb begin
        if (DIF != 0) begin
            sa_re = SW'(p_re_q);
            sa_im = SW'(p_im_q);
            sb_re = SW'(y_re);
            sb_im = SW'(y_im);
        end else begin
            sa_re = SW'(p_re_q) + SW'(y_re);
            sa_im = SW'(p_im_q) + SW'(y_im);
            sb_re = SW'(p_re_q) - SW'(y_re);
            sb_im = SW'(p_im_q) - SW'(y_im);
        end
        ha_re = halve(sa_re, scale2_q);
        ha_im = halve(sa_im, scale2_q);
        hb_re = halve(sb_re, scale2_q);
        hb_im = halve(sb_im, scale2_q);
    end

    assign outa_re_d = DW'(sat(64'(ha_re), DW));
    assign outa_im_d = DW'(sat(64'(ha_im), DW));
    assign outb_re_d = DW'(sat(64'(hb_re), DW));
    assign outb_im_d = DW'(sat(64'(hb_im), DW));
    assign clamp_d   = sat_hit(64'(ha_re), DW) || sat_hit(64'(ha_im), DW) ||
                       sat_hit(64'(hb_re), DW) || sat_hit(64'(hb_im), DW);

    // A fresh clamp outranks a simultaneous clear so no overflow event is lost.
    assign ovf_d = (ce && v2_q && clamp_d) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            outa_re_q   <= '0;
            outa_im_q   <= '0;
            outb_re_q   <= '0;
            outb_im_q   <= '0;
        end else begin
            ovf_q <= ovf_d;
            if (ce) begin
                out_valid_q <= v2_q;
                if (v2_q) begin
                    outa_re_q <= outa_re_d;
                    outa_im_q <= outa_im_d;
                    outb_re_q <= outb_re_d;
                    outb_im_q <= outb_im_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign ovf_flag  = ovf_q;
    assign outa_re   = outa_re_q;
    assign outa_im   = outa_im_q;
    assign outb_re   = outb_re_q;
    assign outb_im   = outb_im_q;

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// tb/tb_butterfly_r2_pipe.sv - directed vector bench for the DIT and DIF butterfly builds
module tb_butterfly_r2_pipe;

    logic clk = 1'b0;
    logic rst, in_valid, inverse, scale, out_ready, ovf_clr;
    logic signed [23:0] a_re, a_im, b_re, b_im;
    logic signed [15:0] w_re, w_im;

    logic in_ready, out_valid, ovf_flag;
    logic signed [23:0] outa_re, outa_im, outb_re, outb_im;
    logic f_in_ready, f_out_valid, f_ovf_flag;
    logic signed [23:0] f_outa_re, f_outa_im, f_outb_re, f_outb_im;

    always #5 clk = ~clk;

    butterfly_r2_pipe #(.DW(24), .TW(16), .TF(13), .DIF(0)) dut_dit (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .w_re(w_re), .w_im(w_im), .inverse(inverse), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .outa_re(outa_re), .outa_im(outa_im), .outb_re(outb_re), .outb_im(outb_im),
        .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
    );

    butterfly_r2_pipe #(.DW(24), .TW(16), .TF(13), .DIF(1)) dut_dif (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f_in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .w_re(w_re), .w_im(w_im), .inverse(inverse), .scale(scale),
        .out_valid(f_out_valid), .out_ready(out_ready),
        .outa_re(f_outa_re), .outa_im(f_outa_im), .outb_re(f_outb_re), .outb_im(f_outb_im),
        .ovf_flag(f_ovf_flag), .ovf_clr(ovf_clr)
    );

    typedef struct {
        string name;
        int a_re, a_im, b_re, b_im, w_re, w_im, inv, scl;
        int ta_re, ta_im, tb_re, tb_im;
        int fa_re, fa_im, fb_re, fb_im;
    } vec_t;

    vec_t vecs[10];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        a_re = 24'(v.a_re);
        a_im = 24'(v.a_im);
        b_re = 24'(v.b_re);
        b_im = 24'(v.b_im);
        w_re = 16'(v.w_re);
        w_im = 16'(v.w_im);
        inverse = (v.inv != 0);
        scale = (v.scl != 0);
        in_valid = 1'b1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic chk_vec(input vec_t v);
        chk({v.name, " dit A.re"}, longint'(outa_re), v.ta_re);
        chk({v.name, " dit A.im"}, longint'(outa_im), v.ta_im);
        chk({v.name, " dit B.re"}, longint'(outb_re), v.tb_re);
        chk({v.name, " dit B.im"}, longint'(outb_im), v.tb_im);
        chk({v.name, " dif valid"}, longint'(f_out_valid), 1);
        chk({v.name, " dif A.re"}, longint'(f_outa_re), v.fa_re);
        chk({v.name, " dif A.im"}, longint'(f_outa_im), v.fa_im);
        chk({v.name, " dif B.re"}, longint'(f_outb_re), v.fb_re);
        chk({v.name, " dif B.im"}, longint'(f_outb_im), v.fb_im);
    endtask

    initial begin
        int lat, tx, rx, stalls, extra;
        logic acc, cons;

        vecs[0] = '{"ident",  1, 2, 3, 4, 8192, 0, 0, 0,   4, 6, -2, -2,   4, 6, -2, -2};
        vecs[1] = '{"mj",     1, 2, 3, 4, 0, -8192, 0, 0,  5, -1, -3, 5,   4, 6, -2, 2};
        vecs[2] = '{"mj_inv", 1, 2, 3, 4, 0, -8192, 1, 0,  -3, 5, 5, -1,   4, 6, 2, -2};
        vecs[3] = '{"rnd_p",  0, 0, 3, 0, 4096, 0, 0, 0,   2, 0, -2, 0,    3, 0, -1, 0};
        vecs[4] = '{"rnd_n",  0, 0, -3, 0, 4096, 0, 0, 0,  -1, 0, 1, 0,    -3, 0, 2, 0};
        vecs[5] = '{"scale",  1, 2, 3, 4, 8192, 0, 0, 1,   2, 3, -1, -1,   2, 3, -1, -1};
        vecs[6] = '{"satp",   8388607, 0, 8388607, 0, 8192, 0, 0, 0,  8388607, 0, 0, 0,  8388607, 0, 0, 0};
        vecs[7] = '{"satp_s", 8388607, 0, 8388607, 0, 8192, 0, 0, 1,  8388607, 0, 0, 0,  8388607, 0, 0, 0};
        vecs[8] = '{"satn",   -8388608, 0, -8388608, 0, 8192, 0, 0, 0,  -8388608, 0, 0, 0,  -8388608, 0, 0, 0};
        vecs[9] = '{"wmin",   0, 0, 1, 0, 0, -32768, 1, 0,  0, 4, 0, -4,   1, 0, 0, -4};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
        inverse = 1'b0; scale = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset outa_re", longint'(outa_re), 0);
        chk("reset outb_im", longint'(outb_im), 0);
        chk("reset ovf_flag", longint'(ovf_flag), 0);
        chk("reset in_ready", longint'(in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i]);
            wait_out(lat);
            chk({vecs[i].name, " latency"}, lat, 3);
            chk_vec(vecs[i]);
            @(posedge clk); #1;
        end

        // Sticky overflow: clear, set, hold, clear, no-set with scale, set-beats-clear.
        ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
        chk("ovf cleared", longint'(ovf_flag), 0);
        apply(vecs[6]); wait_out(lat);
        chk("ovf set", longint'(ovf_flag), 1);
        chk("dif ovf set", longint'(f_ovf_flag), 1);
        repeat (3) @(posedge clk); #1;
        chk("ovf sticky", longint'(ovf_flag), 1);
        ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
        chk("ovf clr", longint'(ovf_flag), 0);
        apply(vecs[7]); wait_out(lat);
        chk("ovf scaled none", longint'(ovf_flag), 0);
        chk("dif ovf scaled none", longint'(f_ovf_flag), 0);
        chk("scaled sat A.re", longint'(outa_re), 8388607);
        ovf_clr = 1'b1;
        apply(vecs[6]); wait_out(lat);
        ovf_clr = 1'b0;
        chk("ovf set wins", longint'(ovf_flag), 1);
        @(posedge clk); #1;

        // Backpressure: six pairs, out_ready low for cycles 4..6.
        tx = 0; rx = 0; stalls = 0;
        for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (tx < 6) begin
                a_re = 24'(tx + 1); a_im = 24'(10 * (tx + 1));
                b_re = 24'(tx + 1); b_im = '0;
                w_re = 16'sd8192; w_im = '0;
                inverse = 1'b0; scale = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("bp in_ready", longint'(in_ready), (cyc >= 4 && cyc <= 6) ? 0 : 1);
            if (!in_ready) stalls++;
            acc = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                chk("bp A.re", longint'(outa_re), 2 * (rx + 1));
                chk("bp A.im", longint'(outa_im), 10 * (rx + 1));
                chk("bp B.re", longint'(outb_re), 0);
                chk("bp B.im", longint'(outb_im), 10 * (rx + 1));
                chk("bp dif A.re", longint'(f_outa_re), 2 * (rx + 1));
                chk("bp dif B.im", longint'(f_outb_im), 10 * (rx + 1));
                rx++;
            end
            if (acc) tx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp results", rx, 6);
        chk("bp stall cycles", stalls, 3);
        extra = 0;
        repeat (4) begin
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        chk("bp no duplicate", extra, 0);

        // Reset with two samples in flight, ovf_flag set and outputs nonzero.
        apply(vecs[6]); @(posedge clk); #1;
        apply(vecs[3]); @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst out_valid", longint'(out_valid), 0);
        chk("rst outa_re", longint'(outa_re), 0);
        chk("rst outa_im", longint'(outa_im), 0);
        chk("rst outb_re", longint'(outb_re), 0);
        chk("rst outb_im", longint'(outb_im), 0);
        chk("rst ovf_flag", longint'(ovf_flag), 0);
        chk("rst dif out_valid", longint'(f_out_valid), 0);
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid || f_out_valid) extra++;
        end
        chk("rst no stale", extra, 0);
        apply(vecs[1]); wait_out(lat);
        chk("post rst latency", lat, 3);
        chk_vec(vecs[1]);
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("post rst single", extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
